// File: rtl/fill_rect_pkg.sv
// fill_rect_pkg: shared definitions for the rectangle filler.
//   - FSM state encodings and state type
//   - fill mode encodings (solid / outline)
//   - default screen geometry
package fill_rect_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic MODE_SOLID   = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  // Legacy state codes kept as constants; the enum reuses them so existing
  // waveform decoders keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_FILL = ST_FILL,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/fill_rect_clip.sv
// fill_rect_clip: combinational clipping of a rectangle request to the screen.
// Ports:
//   x0_i, w_i   : left column and width
//   y0_i, h_i   : top row and height
//   xe_o, ye_o  : inclusive right column / bottom row after clipping
//                 (one bit wider than the coordinates; meaningless if empty)
//   empty_o     : request covers no on-screen pixel
module fill_rect_clip
  import fill_rect_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic [X_W-1:0] x0_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [Y_W-1:0] h_i,
  output logic [X_W:0]   xe_o,
  output logic [Y_W:0]   ye_o,
  output logic           empty_o
);

  localparam logic [X_W:0] SW    = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SH    = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
  localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

  logic [X_W:0] x_sum;
  logic [X_W:0] x_lim;
  logic [Y_W:0] y_sum;
  logic [Y_W:0] y_lim;

  always_comb begin
    // Sums are one bit wider so x0+w cannot wrap before clipping.
    x_sum   = {1'b0, x0_i} + {1'b0, w_i};
    y_sum   = {1'b0, y0_i} + {1'b0, h_i};
    x_lim   = (x_sum > SW) ? SW : x_sum;
    y_lim   = (y_sum > SH) ? SH : y_sum;
    xe_o    = x_lim - X_ONE;
    ye_o    = y_lim - Y_ONE;
    empty_o = (w_i == '0) || (h_i == '0) ||
              ({1'b0, x0_i} >= SW) || ({1'b0, y0_i} >= SH);
  end

endmodule

// File: rtl/fill_rect.sv
// fill_rect: streams the pixels of a solid or outlined rectangle in raster
// order to a VGA write port with a ready/plot handshake.
// Ports:
//   clock, reset          : clock, synchronous active-low reset
//   start                 : one-cycle job request (latches x0,y0,w,h,colour,mode)
//   x0, y0, w, h          : rectangle origin and size
//   colour, mode          : fill colour; 0 = solid, 1 = outline
//   ready                 : downstream accepts the current pixel
//   xOut, yOut, colourOut : current pixel (registered)
//   plot                  : pixel valid
//   busy                  : job active (FILL or DONE)
//   done                  : one-cycle completion pulse
module fill_rect
  import fill_rect_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  input  logic [C_W-1:0] colour,
  input  logic           mode,
  input  logic           ready,
  output logic [X_W-1:0] xOut,
  output logic [Y_W-1:0] yOut,
  output logic [C_W-1:0] colourOut,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [X_W-1:0] x0_q, x0_d;
  logic [Y_W-1:0] y0_q, y0_d;
  logic [X_W:0]   xe_q, xe_d;
  logic [Y_W:0]   ye_q, ye_d;
  logic [C_W-1:0] col_q, col_d;
  logic           mode_q, mode_d;

  logic [X_W:0]   xe_c;
  logic [Y_W:0]   ye_c;
  logic           empty_c;
  logic           at_xe;
  logic           at_ye;
  logic           outline_mid;

  fill_rect_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_clip (
    .x0_i    (x0),
    .w_i     (w),
    .y0_i    (y0),
    .h_i     (h),
    .xe_o    (xe_c),
    .ye_o    (ye_c),
    .empty_o (empty_c)
  );

  assign at_xe = ({1'b0, x_q} == xe_q);
  assign at_ye = ({1'b0, y_q} == ye_q);
  // Interior outline rows only emit the two edge columns.
  assign outline_mid = (mode_q == MODE_OUTLINE) && (y_q != y0_q) && !at_ye;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    col_d   = col_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
      end
      S_FILL: begin
        if (ready) begin
          if (at_xe && at_ye) begin
            state_d = S_DONE;
            x_d     = '0;
            y_d     = '0;
          end else if (at_xe) begin
            x_d = x0_q;
            y_d = y_q + Y_W'(1);
          end else if (outline_mid && (x_q == x0_q)) begin
            x_d = xe_q[X_W-1:0];
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase

    // A new request overrides whatever job is in flight.
    if (start) begin
      x0_d   = x0;
      y0_d   = y0;
      xe_d   = xe_c;
      ye_d   = ye_c;
      col_d  = colour;
      mode_d = mode;
      if (empty_c) begin
        state_d = S_DONE;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = S_FILL;
        x_d     = x0;
        y_d     = y0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      col_q   <= '0;
      mode_q  <= MODE_SOLID;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
    end
  end

  assign xOut      = x_q;
  assign yOut      = y_q;
  assign colourOut = col_q;
  assign plot      = (state_q == S_FILL);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fill_rect.sv
// tb_fill_rect: randomized and directed stimulus for fill_rect, checked every
// cycle against a pixel-list reference model, plus literal expectations for
// the characteristic jobs.
module tb_fill_rect;
  import fill_rect_pkg::*;

  localparam int SW = 160;
  localparam int SH = 120;

  logic       clock, reset, start, mode, ready;
  logic [7:0] x0, w, xOut;
  logic [6:0] y0, h, yOut;
  logic [2:0] colour, colourOut;
  logic       plot, busy, done;

  fill_rect #(
    .SCREEN_W (SW),
    .SCREEN_H (SH),
    .X_W      (8),
    .Y_W      (7),
    .C_W      (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour    (colour),
    .mode      (mode),
    .ready     (ready),
    .xOut      (xOut),
    .yOut      (yOut),
    .colourOut (colourOut),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
  } pix_t;

  // Reference model: remaining pixels of the current job, completed transfers.
  pix_t mq[$];
  pix_t xfer[$];
  int   m_done = 0;
  int   m_col  = 0;
  int   rel    = 0;

  // Observation log of the DUT for the directed literal checks.
  int obs_plot, first_plot_rel, first_x, first_y;
  int done_cnt, done_rel, busy_cnt, hold00;
  bit rnd_ready = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Enumerate the clipped rectangle in raster order, keeping border pixels
  // only for outline jobs.
  function automatic void build(input int ax, input int ay, input int aw,
                                input int ah, input logic am);
    int   xe, ye;
    pix_t p;
    mq.delete();
    if (aw == 0 || ah == 0 || ax >= SW || ay >= SH) return;
    xe = ((ax + aw > SW) ? SW : ax + aw) - 1;
    ye = ((ay + ah > SH) ? SH : ay + ah) - 1;
    for (int yy = ay; yy <= ye; yy++)
      for (int xx = ax; xx <= xe; xx++)
        if (am == MODE_SOLID || yy == ay || yy == ye || xx == ax || xx == xe) begin
          p.x = xx;
          p.y = yy;
          mq.push_back(p);
        end
  endfunction

  function automatic int exp_count(input int ax, input int ay, input int aw,
                                   input int ah, input logic am);
    int xs, ys;
    if (aw == 0 || ah == 0 || ax >= SW || ay >= SH) return 0;
    xs = ((ax + aw > SW) ? SW : ax + aw) - ax;
    ys = ((ay + ah > SH) ? SH : ay + ah) - ay;
    if (am == MODE_SOLID || xs == 1 || ys == 1) return xs * ys;
    return 2 * xs + 2 * ys - 4;
  endfunction

  always @(posedge clock) begin : cmp
    int ep;
    rel++;
    if (!reset) begin
      mq.delete();
      m_done = 0;
      m_col  = 0;
    end else if (start) begin
      build(int'(x0), int'(y0), int'(w), int'(h), mode);
      m_col  = int'(colour);
      m_done = (mq.size() == 0) ? 1 : 0;
      rel    = 1;
    end else if (mq.size() > 0) begin
      if (ready) begin
        xfer.push_back(mq.pop_front());
        if (mq.size() == 0) m_done = 1;
      end
    end else begin
      m_done = 0;
    end
    #1;
    ep = (mq.size() > 0) ? 1 : 0;
    chk("plot", int'(plot), ep);
    chk("done", int'(done), m_done);
    chk("busy", int'(busy), (ep != 0 || m_done != 0) ? 1 : 0);
    if (ep != 0) begin
      chk("xOut", int'(xOut), mq[0].x);
      chk("yOut", int'(yOut), mq[0].y);
      chk("colourOut", int'(colourOut), m_col);
    end else if (m_done == 0) begin
      chk("xOut_idle", int'(xOut), 0);
      chk("yOut_idle", int'(yOut), 0);
    end
    if (plot === 1'b1) begin
      obs_plot++;
      if (first_plot_rel < 0) begin
        first_plot_rel = rel;
        first_x = int'(xOut);
        first_y = int'(yOut);
      end
      if (xOut == 8'd0 && yOut == 7'd0) hold00++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_rel = rel;
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic clear_log();
    xfer.delete();
    obs_plot = 0; first_plot_rel = -1; first_x = -1; first_y = -1;
    done_cnt = 0; done_rel = -1; busy_cnt = 0; hold00 = 0;
  endtask

  task automatic drive_ready();
    ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Presents a job for one cycle, then scrambles the request fields so the
  // DUT has to rely on its latched copy.
  task automatic launch(input int ax, input int ay, input int aw, input int ah,
                        input int ac, input logic am);
    @(negedge clock);
    clear_log();
    x0 = 8'(ax); y0 = 7'(ay); w = 8'(aw); h = 7'(ah);
    colour = 3'(ac); mode = am; start = 1'b1;
    drive_ready();
    @(negedge clock);
    start = 1'b0;
    x0 = 8'($urandom); y0 = 7'($urandom); w = 8'($urandom); h = 7'($urandom);
    colour = 3'($urandom); mode = 1'($urandom);
    drive_ready();
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      drive_ready();
      n++;
    end
    chk("done_timeout", int'(done === 1'b1), 1);
  endtask

  task automatic chk_unique(input string nm);
    int seen[int];
    int dups = 0;
    foreach (xfer[i]) begin
      int k;
      k = xfer[i].x * 256 + xfer[i].y;
      if (seen.exists(k)) dups++;
      seen[k] = 1;
    end
    chk(nm, dups, 0);
  endtask

  task automatic chk_pix(input string nm, input int idx, input int ex, input int ey);
    if (idx < xfer.size()) begin
      chk({nm, "_x"}, xfer[idx].x, ex);
      chk({nm, "_y"}, xfer[idx].y, ey);
    end else begin
      chk({nm, "_missing"}, xfer.size(), idx + 1);
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_plot"}, int'(plot), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_x"}, int'(xOut), 0);
    chk({nm, "_y"}, int'(yOut), 0);
    chk({nm, "_col"}, int'(colourOut), 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : drv
    int ex39x[6];
    int ex39y[6];
    int ax, ay, aw, ah, ac;
    logic am;
    ex39x = '{2, 3, 4, 2, 3, 4};
    ex39y = '{3, 3, 3, 4, 4, 4};

    reset = 1'b0; start = 1'b0; ready = 1'b1; mode = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour = '0;
    clear_log();
    repeat (3) @(negedge clock);
    chk_zero_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    // Solid 3x2 at (2,3), always ready.
    rnd_ready = 1'b0;
    launch(2, 3, 3, 2, 5, MODE_SOLID);
    wait_done(50);
    chk("solid_first_plot_cycle", first_plot_rel, 1);
    chk("solid_plot_cycles", obs_plot, 6);
    chk("solid_done_cycle", done_rel, 7);
    chk("solid_count", xfer.size(), 6);
    for (int i = 0; i < 6; i++) chk_pix("solid_seq", i, ex39x[i], ex39y[i]);
    @(negedge clock);

    // Outline 4x4 at origin.
    launch(0, 0, 4, 4, 1, MODE_OUTLINE);
    wait_done(50);
    chk("outline_count", xfer.size(), 12);
    chk_pix("outline_row1_a", 4, 0, 1);
    chk_pix("outline_row1_b", 5, 3, 1);
    chk_unique("outline_dups");
    @(negedge clock);

    // Clipped at the bottom-right corner.
    launch(158, 118, 10, 10, 4, MODE_SOLID);
    wait_done(50);
    chk("clip_count", xfer.size(), 4);
    chk_pix("clip_first", 0, 158, 118);
    chk_pix("clip_last", 3, 159, 119);
    @(negedge clock);

    // Zero-width job.
    launch(5, 5, 0, 3, 2, MODE_SOLID);
    wait_done(10);
    @(negedge clock);
    @(negedge clock);
    chk("empty_done_cycle", done_rel, 1);
    chk("empty_plot_cycles", obs_plot, 0);
    chk("empty_busy_cycles", busy_cnt, 1);

    // Solid 2x1 with ready low for three cycles after the first pixel.
    @(negedge clock);
    clear_log();
    x0 = 8'd0; y0 = 7'd0; w = 8'd2; h = 7'd1; colour = 3'd3;
    mode = MODE_SOLID; start = 1'b1; ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    ready = 1'b1;
    wait_done(20);
    chk("stall_hold_cycles", hold00, 4);
    chk("stall_transfers", xfer.size(), 2);
    chk("stall_done_cycle", done_rel, 6);
    @(negedge clock);

    // Restart mid-FILL.
    rnd_ready = 1'b1;
    launch(10, 10, 5, 5, 2, MODE_SOLID);
    repeat (6) begin
      @(negedge clock);
      drive_ready();
    end
    chk("abort_no_done", done_cnt, 0);
    launch(20, 30, 2, 2, 6, MODE_OUTLINE);
    wait_done(100);
    chk("restart_first_x", first_x, 20);
    chk("restart_first_y", first_y, 30);
    chk("restart_done_count", done_cnt, 1);
    chk("restart_count", xfer.size(), 4);
    @(negedge clock);

    // Reset mid-job.
    launch(40, 50, 6, 6, 7, MODE_SOLID);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk_zero_outputs("midreset");
    repeat (10) begin
      @(negedge clock);
      drive_ready();
    end
    chk("midreset_no_done", done_cnt, 0);

    // Randomized jobs, some interrupted by a second request.
    for (int j = 0; j < 60; j++) begin
      ax = $urandom_range(0, 165);
      ay = $urandom_range(0, 125);
      aw = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 14);
      ah = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9);
      ac = $urandom_range(0, 7);
      am = ($urandom_range(0, 1) == 0) ? MODE_SOLID : MODE_OUTLINE;
      if ($urandom_range(0, 2) == 0) begin
        ax = $urandom_range(145, 159);
        ay = $urandom_range(110, 119);
      end
      launch(ax, ay, aw, ah, ac, am);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 4)) begin
          @(negedge clock);
          drive_ready();
        end
        ax = $urandom_range(0, 150);
        ay = $urandom_range(0, 110);
        aw = $urandom_range(1, 8);
        ah = $urandom_range(1, 6);
        am = ($urandom_range(0, 1) == 0) ? MODE_SOLID : MODE_OUTLINE;
        launch(ax, ay, aw, ah, ac, am);
      end
      wait_done(600);
      chk("rand_count", xfer.size(), exp_count(ax, ay, aw, ah, am));
      chk_unique("rand_dups");
      @(negedge clock);
      drive_ready();
    end

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
